// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  // Largest supported memory read latency and the width of the wait counter.
  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory bus of the unified-memory arbiter.
//
// Handshake: a requester raises *_req with stable address/data and holds it
// until the matching *_ack pulses for exactly one cycle; *_rdata is only
// meaningful in that ack cycle. The memory side gets one mem_en cycle per
// access and returns the word on mem_rdata MEM_LAT clock edges later.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              if_stall;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              dm_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Pipeline stages plus memory view.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_perf_cnt.sv
// 16-bit saturating event counter, synchronous active-low reset.
module mem_arb_perf_cnt (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_inc,
  output logic [15:0] o_count
);

  logic [15:0] r_count;

  // Count events, sticking at all-ones; cleared only by reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_count <= 16'h0000;
    end else if (i_inc && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'h0001;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port unified memory between IF and MEM stages.
// Data accesses always win over fetches (the MEM instruction is older).
// Optional conflict counter: define MEM_PORT_ARBITER_PERF_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic               CLK,
  input  logic               RST,
  mem_port_arbiter_if.slave  bus,
  output logic [15:0]        perf_conflicts,
  output arb_state_e         o_dbg_state
);

  // Latency clamped into the supported 1..MEM_LAT_MAX range.
  localparam int LAT_C = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX :
                         ((MEM_LAT < 1) ? 1 : MEM_LAT);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LAT_C - 1);

  arb_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  owner_e            r_owner;
  logic              r_we;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  arb_state_e        w_state_next;
  logic [CNT_W-1:0]  w_cnt_next;
  owner_e            w_owner_next;
  logic              w_we_next;
  logic              w_issue_dm;
  logic              w_issue_if;
  logic              w_enter_resp;
  logic [ADDR_W-1:0] w_addr;

  // Issue only from IDLE and never while reset is held, so mem_* stay 0 in reset.
  assign w_issue_dm   = RST && (r_state == IDLE) && bus.dm_req;
  assign w_issue_if   = RST && (r_state == IDLE) && !bus.dm_req && bus.if_req;
  assign w_enter_resp = (w_state_next == RESP);

  // State register; the read word is sampled on the edge that moves into RESP.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_owner    <= OWN_IF;
      r_we       <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_owner <= w_owner_next;
      r_we    <= w_we_next;
      if (w_enter_resp) begin
        if (w_owner_next == OWN_DM) begin
          r_dm_rdata <= w_we_next ? '0 : bus.mem_rdata;
        end else begin
          r_if_rdata <= w_we_next ? '0 : bus.mem_rdata;
        end
      end
    end
  end

  // Next-state logic: IDLE issues, WAIT counts down, RESP always returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_owner_next = r_owner;
    w_we_next    = r_we;
    case (r_state)
      IDLE: begin
        if (w_issue_dm || w_issue_if) begin
          w_owner_next = w_issue_dm ? OWN_DM : OWN_IF;
          w_we_next    = w_issue_dm && bus.dm_we;
          if ((w_issue_dm && bus.dm_we) || (LAT_C == 1)) begin
            w_state_next = RESP;
            w_cnt_next   = '0;
          end else begin
            w_state_next = WAIT;
            w_cnt_next   = LAT_M1;
          end
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Output logic: memory strobes in the issue cycle, acks in RESP for the owner.
  always_comb begin
    w_addr = '0;
    if (w_issue_dm) begin
      w_addr = bus.dm_addr;
    end else if (w_issue_if) begin
      w_addr = bus.if_addr;
    end
    bus.mem_en    = w_issue_dm || w_issue_if;
    bus.mem_we    = w_issue_dm && bus.dm_we;
    bus.mem_addr  = w_addr;
    bus.mem_wdata = w_issue_dm ? bus.dm_wdata : '0;
    bus.if_ack    = (r_state == RESP) && (r_owner == OWN_IF);
    bus.dm_ack    = (r_state == RESP) && (r_owner == OWN_DM);
    bus.if_stall  = bus.if_req && !bus.if_ack;
    bus.dm_stall  = bus.dm_req && !bus.dm_ack;
  end

  assign bus.if_rdata = r_if_rdata;
  assign bus.dm_rdata = r_dm_rdata;
  assign o_dbg_state  = r_state;

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic w_dm_busy;
  logic w_conflict;

  // A waiting fetch is blocked whenever data is being issued or owns the memory.
  assign w_dm_busy  = (r_state == IDLE) ? w_issue_dm : (r_owner == OWN_DM);
  assign w_conflict = bus.if_req && w_dm_busy;

  mem_arb_perf_cnt u_perf_cnt (
    .CLK     (CLK),
    .RST     (RST),
    .i_inc   (w_conflict),
    .o_count (perf_conflicts)
  );
`else
  assign perf_conflicts = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (MEM_LAT=2 instance and MEM_LAT=1 instance).
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        CLK;
  logic        RST;
  logic [15:0] perf0;
  logic [15:0] perf1;
  arb_state_e  st0;
  arb_state_e  st1;
  int          total;
  int          bad;

`ifdef MEM_PORT_ARBITER_PERF_EN
  localparam logic [15:0] EXP_CONFLICTS = 16'd3;
`else
  localparam logic [15:0] EXP_CONFLICTS = 16'd0;
`endif

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .CLK(CLK), .RST(RST), .bus(bus0.slave), .perf_conflicts(perf0), .o_dbg_state(st0)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .CLK(CLK), .RST(RST), .bus(bus1.slave), .perf_conflicts(perf1), .o_dbg_state(st1)
  );

  // Clock and watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to 1ns after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick();
    tick();
    #1;
    total++; if (st0 !== IDLE) begin bad++; $display("FAIL rst_state: got %0d want %0d", st0, IDLE); end
    total++; if (bus0.if_ack !== 1'b0 || bus0.dm_ack !== 1'b0) begin bad++; $display("FAIL rst_ack: got %b%b want 00", bus0.if_ack, bus0.dm_ack); end
    total++; if (bus0.if_rdata !== 32'h0 || bus0.dm_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h %h want 0 0", bus0.if_rdata, bus0.dm_rdata); end
    total++; if ({bus0.mem_en, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata} !== 66'h0) begin bad++; $display("FAIL rst_mem: got en=%b we=%b a=%h d=%h want 0", bus0.mem_en, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata); end
    total++; if (perf0 !== 16'h0) begin bad++; $display("FAIL rst_perf: got %h want 0", perf0); end
    RST = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    bus0.if_req = 1'b1; bus0.if_addr = 32'h0000_0010; bus0.mem_rdata = 32'hBAD0_BAD0;
    #1;
    total++; if (bus0.mem_en !== 1'b1 || bus0.mem_we !== 1'b0 || bus0.mem_addr !== 32'h10) begin bad++; $display("FAIL fetch_issue: got en=%b we=%b a=%h want 1 0 10", bus0.mem_en, bus0.mem_we, bus0.mem_addr); end
    total++; if (bus0.if_stall !== 1'b1 || bus0.if_ack !== 1'b0) begin bad++; $display("FAIL fetch_stall_t: got stall=%b ack=%b want 1 0", bus0.if_stall, bus0.if_ack); end
    tick();
    bus0.mem_rdata = 32'h2008_0005;
    #1;
    total++; if (bus0.mem_en !== 1'b0 || bus0.if_stall !== 1'b1 || bus0.if_ack !== 1'b0 || st0 !== WAIT) begin bad++; $display("FAIL fetch_t1: got en=%b stall=%b ack=%b st=%0d want 0 1 0 %0d", bus0.mem_en, bus0.if_stall, bus0.if_ack, st0, WAIT); end
    tick();
    bus0.mem_rdata = 32'hBAD0_BAD0;
    #1;
    total++; if (bus0.if_ack !== 1'b1 || bus0.if_rdata !== 32'h2008_0005) begin bad++; $display("FAIL fetch_ack: got ack=%b rdata=%h want 1 20080005", bus0.if_ack, bus0.if_rdata); end
    total++; if (bus0.if_stall !== 1'b0 || bus0.mem_en !== 1'b0) begin bad++; $display("FAIL fetch_ack_misc: got stall=%b en=%b want 0 0", bus0.if_stall, bus0.mem_en); end
    bus0.if_req = 1'b0;
    tick();
    total++; if (st0 !== IDLE || bus0.if_ack !== 1'b0 || bus0.if_rdata !== 32'h2008_0005) begin bad++; $display("FAIL fetch_idle: got st=%0d ack=%b rdata=%h want %0d 0 20080005", st0, bus0.if_ack, bus0.if_rdata, IDLE); end
  endtask

  task automatic test_conflict();
    logic [15:0] p0;
    p0 = perf0;
    bus0.if_req = 1'b1; bus0.if_addr = 32'h10;
    bus0.dm_req = 1'b1; bus0.dm_we = 1'b0; bus0.dm_addr = 32'h44; bus0.mem_rdata = 32'hBAD0_BAD0;
    #1;
    total++; if (bus0.mem_en !== 1'b1 || bus0.mem_addr !== 32'h44 || bus0.mem_we !== 1'b0) begin bad++; $display("FAIL conf_issue_dm: got en=%b a=%h we=%b want 1 44 0", bus0.mem_en, bus0.mem_addr, bus0.mem_we); end
    total++; if (bus0.if_stall !== 1'b1 || bus0.dm_stall !== 1'b1) begin bad++; $display("FAIL conf_stalls: got if=%b dm=%b want 1 1", bus0.if_stall, bus0.dm_stall); end
    tick();
    bus0.mem_rdata = 32'h1234_5678;
    #1;
    total++; if (bus0.mem_en !== 1'b0) begin bad++; $display("FAIL conf_t1_en: got %b want 0", bus0.mem_en); end
    tick();
    bus0.mem_rdata = 32'hBAD0_BAD0;
    #1;
    total++; if (bus0.dm_ack !== 1'b1 || bus0.dm_rdata !== 32'h1234_5678 || bus0.if_ack !== 1'b0) begin bad++; $display("FAIL conf_dm_ack: got ack=%b rdata=%h ifack=%b want 1 12345678 0", bus0.dm_ack, bus0.dm_rdata, bus0.if_ack); end
    total++; if (bus0.mem_en !== 1'b0) begin bad++; $display("FAIL conf_resp_no_issue: got %b want 0", bus0.mem_en); end
    bus0.dm_req = 1'b0;
    tick();
    total++; if (bus0.mem_en !== 1'b1 || bus0.mem_addr !== 32'h10 || bus0.dm_ack !== 1'b0) begin bad++; $display("FAIL conf_fetch_issue: got en=%b a=%h dmack=%b want 1 10 0", bus0.mem_en, bus0.mem_addr, bus0.dm_ack); end
    total++; if (perf0 !== p0 + EXP_CONFLICTS) begin bad++; $display("FAIL conf_perf: got %0d want %0d", perf0, p0 + EXP_CONFLICTS); end
    tick();
    bus0.mem_rdata = 32'h2008_0005;
    tick();
    bus0.mem_rdata = 32'hBAD0_BAD0;
    #1;
    total++; if (bus0.if_ack !== 1'b1 || bus0.if_rdata !== 32'h2008_0005 || bus0.dm_rdata !== 32'h1234_5678) begin bad++; $display("FAIL conf_fetch_ack: got ack=%b if=%h dm=%h want 1 20080005 12345678", bus0.if_ack, bus0.if_rdata, bus0.dm_rdata); end
    bus0.if_req = 1'b0;
    tick();
    total++; if (perf0 !== p0 + EXP_CONFLICTS) begin bad++; $display("FAIL conf_perf_hold: got %0d want %0d", perf0, p0 + EXP_CONFLICTS); end
  endtask

  task automatic test_write();
    bus0.dm_req = 1'b1; bus0.dm_we = 1'b1; bus0.dm_addr = 32'h40; bus0.dm_wdata = 32'hDEAD_BEEF;
    #1;
    total++; if (bus0.mem_en !== 1'b1 || bus0.mem_we !== 1'b1 || bus0.mem_addr !== 32'h40 || bus0.mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_issue: got en=%b we=%b a=%h d=%h want 1 1 40 deadbeef", bus0.mem_en, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata); end
    total++; if (bus0.dm_stall !== 1'b1) begin bad++; $display("FAIL wr_stall: got %b want 1", bus0.dm_stall); end
    tick();
    total++; if (bus0.dm_ack !== 1'b1 || bus0.dm_rdata !== 32'h0 || bus0.mem_en !== 1'b0 || bus0.dm_stall !== 1'b0) begin bad++; $display("FAIL wr_ack: got ack=%b rdata=%h en=%b stall=%b want 1 0 0 0", bus0.dm_ack, bus0.dm_rdata, bus0.mem_en, bus0.dm_stall); end
    bus0.dm_req = 1'b0; bus0.dm_we = 1'b0;
    tick();
    total++; if (st0 !== IDLE || bus0.dm_ack !== 1'b0) begin bad++; $display("FAIL wr_idle: got st=%0d ack=%b want %0d 0", st0, bus0.dm_ack, IDLE); end
  endtask

  task automatic test_back_to_back();
    int n_en;
    n_en = 0;
    bus0.if_req = 1'b1; bus0.if_addr = 32'h20; bus0.mem_rdata = 32'h1111_1111;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus0.mem_en === 1'b1) n_en++;
      if (c == 2) begin
        total++; if (bus0.mem_en !== 1'b0 || bus0.if_ack !== 1'b1) begin bad++; $display("FAIL b2b_t2: got en=%b ack=%b want 0 1", bus0.mem_en, bus0.if_ack); end
      end
      if (c == 3) begin
        total++; if (bus0.mem_en !== 1'b1 || bus0.mem_addr !== 32'h24) begin bad++; $display("FAIL b2b_t3: got en=%b a=%h want 1 24", bus0.mem_en, bus0.mem_addr); end
      end
      tick();
      if (c == 2) bus0.if_addr = 32'h24;
    end
    total++; if (n_en != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", n_en); end
    tick();
    bus0.if_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    int acks;
    acks = 0;
    bus0.dm_req = 1'b1; bus0.dm_we = 1'b0; bus0.dm_addr = 32'h44; bus0.mem_rdata = 32'hBAD0_BAD0;
    #1;
    total++; if (bus0.mem_en !== 1'b1) begin bad++; $display("FAIL rmid_issue: got %b want 1", bus0.mem_en); end
    tick();
    total++; if (st0 !== WAIT) begin bad++; $display("FAIL rmid_wait: got %0d want %0d", st0, WAIT); end
    RST = 1'b0; bus0.dm_req = 1'b0; bus0.mem_rdata = 32'h55AA_55AA;
    tick();
    total++; if (st0 !== IDLE || bus0.dm_ack !== 1'b0 || bus0.if_ack !== 1'b0) begin bad++; $display("FAIL rmid_state: got st=%0d acks=%b%b want %0d 00", st0, bus0.if_ack, bus0.dm_ack, IDLE); end
    total++; if (bus0.dm_rdata !== 32'h0 || bus0.if_rdata !== 32'h0 || bus0.mem_en !== 1'b0 || perf0 !== 16'h0) begin bad++; $display("FAIL rmid_outs: got dm=%h if=%h en=%b perf=%h want 0", bus0.dm_rdata, bus0.if_rdata, bus0.mem_en, perf0); end
    RST = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus0.dm_ack === 1'b1 || bus0.if_ack === 1'b1) acks++;
    end
    total++; if (acks != 0) begin bad++; $display("FAIL rmid_no_ack: got %0d ack cycles want 0", acks); end
  endtask

  task automatic test_lat1();
    bus1.dm_req = 1'b1; bus1.dm_we = 1'b0; bus1.dm_addr = 32'h80; bus1.mem_rdata = 32'hCAFE_F00D;
    #1;
    total++; if (bus1.mem_en !== 1'b1 || bus1.mem_addr !== 32'h80) begin bad++; $display("FAIL lat1_issue: got en=%b a=%h want 1 80", bus1.mem_en, bus1.mem_addr); end
    tick();
    bus1.mem_rdata = 32'hBAD0_BAD0;
    #1;
    total++; if (bus1.dm_ack !== 1'b1 || bus1.dm_rdata !== 32'hCAFE_F00D || st1 !== RESP) begin bad++; $display("FAIL lat1_ack: got ack=%b rdata=%h st=%0d want 1 cafef00d %0d", bus1.dm_ack, bus1.dm_rdata, st1, RESP); end
    bus1.dm_req = 1'b0;
    tick();
    total++; if (st1 !== IDLE || bus1.dm_ack !== 1'b0) begin bad++; $display("FAIL lat1_idle: got st=%0d ack=%b want %0d 0", st1, bus1.dm_ack, IDLE); end
  endtask

  // Main sequence
  initial begin
    total = 0;
    bad   = 0;
    RST   = 1'b0;
    bus0.if_req = 1'b0; bus0.if_addr = '0; bus0.dm_req = 1'b0; bus0.dm_we = 1'b0;
    bus0.dm_addr = '0; bus0.dm_wdata = '0; bus0.mem_rdata = '0;
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.dm_req = 1'b0; bus1.dm_we = 1'b0;
    bus1.dm_addr = '0; bus1.dm_wdata = '0; bus1.mem_rdata = '0;
    test_reset();
    test_fetch();
    test_conflict();
    test_write();
    test_back_to_back();
    test_lat1();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
